regfile_mp_sb: RTL and testbench
================================

REGFILE_MP_SB -- requirements
Module: regfile_mp_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter NUM_RD, default 3, meaning number of read ports (1..8).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port write_enable  input  1  writeback strobe.
REQ-007 The block SHALL have port w_addr  input  ADDR_W  writeback address.
REQ-008 The block SHALL have port w_data  input  DATA_W  writeback data.
REQ-009 The block SHALL have port alloc_en  input  1  issue-stage strobe marking a destination register pending.
REQ-010 The block SHALL have port alloc_addr  input  ADDR_W  register to mark pending.
REQ-011 The block SHALL have port clear_req  input  1  single-cycle request to zero the whole file.
REQ-012 The block SHALL have port rd_en  input  NUM_RD  per-port read enable.
REQ-013 The block SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-014 The block SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
REQ-015 The block SHALL have port rd_busy  output  NUM_RD  per-port pending flag for the addressed register.
REQ-016 The block SHALL have port ready  output  1  high when file is usable (not clearing).
REQ-017 The block SHALL have port busy_count  output  ADDR_W+1  number of registers currently pending.

Function
REQ-018 Storage SHALL be DEPTH x DATA_W registers plus DEPTH busy bits; register 0 SHALL always read 0 and never be busy.
REQ-019 Writes SHALL occur on the rising clk edge when write_enable=1, ready=1, w_addr!=0; otherwise ignored.
REQ-020 Reads SHALL be combinational, zero latency; port k outputs 0 when rd_en[k]=0, rd_addr_k=0, or ready=0.
REQ-021 Write-through bypass: when write_enable=1, ready=1, w_addr!=0 and rd_addr_k==w_addr, port k SHALL output w_data in the same cycle.
REQ-022 rd_busy[k] SHALL equal busy[rd_addr_k] AND rd_en[k] AND ready, except it SHALL be 0 when the same-cycle write targets that address and no same-cycle alloc targets it.
REQ-023 An accepted write (per REQ-019) SHALL clear busy[w_addr] at the clock edge.
REQ-024 alloc_en=1 with ready=1 and alloc_addr!=0 SHALL set busy[alloc_addr] at the clock edge.
REQ-025 Simultaneous alloc and write to the same address: alloc SHALL win (busy remains/becomes 1, data still written).
REQ-026 busy_count SHALL be registered, equal to the population count of busy bits after each edge; alloc of an already-busy register and write to a non-busy register SHALL not change it.
REQ-027 Controller SHALL have two states: CLEAR and RUN.
REQ-028 In CLEAR, an internal ADDR_W-bit sweep counter SHALL zero one register and its busy bit per cycle, from 0 up to DEPTH-1; after zeroing DEPTH-1 the state SHALL go to RUN next edge.
REQ-029 A CLEAR sweep SHALL take exactly DEPTH cycles; ready SHALL be 0 throughout and 1 from the first RUN cycle.
REQ-030 clear_req=1 in RUN SHALL enter CLEAR at the next edge with counter=0 and all busy bits cleared at once (busy_count=0 next cycle).
REQ-031 clear_req, alloc_en and write_enable SHALL be ignored while in CLEAR; the sweep SHALL not restart.
REQ-032 Same-cycle clear_req and write/alloc in RUN: clear SHALL take priority; the write and alloc are discarded.

Reset
REQ-033 reset=1 at a clock edge SHALL force state CLEAR, counter 0, all busy bits 0, busy_count 0, regardless of any other input.
REQ-034 While reset=1 and after it, ready SHALL be 0 until the DEPTH-cycle sweep completes; rd_data and rd_busy SHALL read all-zero.
REQ-035 reset asserted mid-sweep SHALL restart the sweep from counter 0.

Verification
REQ-036 Reset release, defaults -> ready=0 for exactly 32 cycles, then 1; all reads 0; busy_count=0.
REQ-037 Write r5=0xDEADBEEF, read port 1 addr 5 same cycle -> rd_data port 1 = 0xDEADBEEF (bypass); next cycle same value from storage.
REQ-038 Alloc r7, next cycle read r7 -> rd_busy=1, busy_count=1; write r7=0x12 -> same-cycle rd_busy=0, next cycle busy_count=0.
REQ-039 Same-cycle alloc r9 and write r9=0x55 -> r9 reads 0x55 and rd_busy=1 afterwards; busy_count=1.
REQ-040 Write r0=0xFFFF_FFFF and alloc r0 -> r0 reads 0, rd_busy=0, busy_count unchanged.
REQ-041 clear_req with r3=0x10 busy, reset pulse at sweep cycle 10 -> ready stays 0 for 32 cycles after reset, r3 reads 0, busy_count=0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-ported register file with a per-register pending (scoreboard) bit.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   write_enable/w_addr/w_data   writeback port; clears the pending bit
//   alloc_en/alloc_addr          issue-stage port; sets the pending bit
//   clear_req                    starts a full-file zeroing sweep
//   rd_en/rd_addr                NUM_RD combinational read ports (packed)
//   rd_data/rd_busy              per-port read data and pending flag (packed)
//   ready                        high when the file is usable (not sweeping)
//   busy_count                   registered count of pending registers
//
// Register 0 always reads zero and is never pending. Reads bypass the
// same-cycle writeback so a consumer sees the value being written back.
module regfile_mp_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     clear_req,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     ready,
    output logic [ADDR_W:0]          busy_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    busy_next;

    logic wr_hit;
    logic wr_commit;
    logic alloc_hit;
    logic alloc_commit;

    // Qualified strobes; a clear request in the same cycle discards both
    // the writeback and the allocation.
    assign wr_hit       = write_enable && ready && (w_addr != '0);
    assign wr_commit    = wr_hit && !clear_req;
    assign alloc_hit    = alloc_en && ready && (alloc_addr != '0);
    assign alloc_commit = alloc_hit && !clear_req;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] s;
        s = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    // Next pending vector: writeback clears first, allocation then wins.
    always_comb begin
        busy_next = busy;
        if (wr_commit) begin
            busy_next[w_addr] = 1'b0;
        end
        if (alloc_commit) begin
            busy_next[alloc_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Controller: CLEAR sweeps one register per cycle, RUN is normal use.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            sweep_cnt  <= '0;
            busy       <= '0;
            busy_count <= '0;
            ready      <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    busy      <= '0;
                    sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    if (sweep_cnt == {ADDR_W{1'b1}}) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state      <= ST_CLEAR;
                        sweep_cnt  <= '0;
                        busy       <= '0;
                        busy_count <= '0;
                        ready      <= 1'b0;
                    end else begin
                        busy       <= busy_next;
                        busy_count <= popcount(busy_next);
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Storage: zeroed by the sweep, otherwise written by accepted writebacks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                regs[sweep_cnt] <= '0;
            end else if (wr_commit) begin
                regs[w_addr] <= w_data;
            end
        end
    end

    // Combinational read ports with writeback bypass.
    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              live;
        logic              wr_match;
        logic              alloc_match;

        assign ra          = rd_addr[k*ADDR_W +: ADDR_W];
        assign live        = rd_en[k] && ready && (ra != '0);
        assign wr_match    = wr_hit && (w_addr == ra);
        assign alloc_match = alloc_hit && (alloc_addr == ra);

        assign rd_data[k*DATA_W +: DATA_W] = !live    ? '0     :
                                             wr_match ? w_data : regs[ra];
        // A writeback in flight resolves the pending flag unless it is
        // re-allocated in the same cycle.
        assign rd_busy[k] = live && busy[ra] && !(wr_match && !alloc_match);
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default parameters).
// Read expectations are pushed to a scoreboard queue as stimulus is driven
// and drained against the DUT outputs once they have settled.
module tb_regfile_mp_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 3;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     write_enable;
    logic [ADDR_W-1:0]        w_addr;
    logic [DATA_W-1:0]        w_data;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic                     clear_req;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     ready;
    logic [ADDR_W:0]          busy_count;

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_enable(write_enable),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .clear_req   (clear_req),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .ready       (ready),
        .busy_count  (busy_count)
    );

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
        logic              bsy;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mdl [DEPTH];
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic idle();
        write_enable = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        alloc_en     = 1'b0;
        alloc_addr   = '0;
        clear_req    = 1'b0;
        rd_en        = '0;
        rd_addr      = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        rd_en[k] = 1'b1;
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic expect_rd(input int k, input logic [DATA_W-1:0] d, input logic b);
        exp_t e;
        e.port = k;
        e.data = d;
        e.bsy  = b;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: compare every queued read against the settled outputs.
    task automatic sb_drain(input string tag);
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_data[e.port*DATA_W +: DATA_W] !== e.data) begin
                n_errors++;
                $display("FAIL %s port%0d rd_data got %h exp %h", tag, e.port,
                         rd_data[e.port*DATA_W +: DATA_W], e.data);
            end
            n_checks++;
            if (rd_busy[e.port] !== e.bsy) begin
                n_errors++;
                $display("FAIL %s port%0d rd_busy got %b exp %b", tag, e.port,
                         rd_busy[e.port], e.bsy);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready got %b exp 0", ready);
        end
        n_checks++;
        if (busy_count !== '0) begin
            n_errors++;
            $display("FAIL reset_busy_count got %0d exp 0", busy_count);
        end
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        set_rd(2, 5'd3);
        for (int k = 0; k < NUM_RD; k++) expect_rd(k, '0, 1'b0);
        sb_drain("reset_hold");
        reset = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            if (n == 16) begin
                for (int k = 0; k < NUM_RD; k++) expect_rd(k, '0, 1'b0);
                sb_drain("reset_sweep");
            end
            step();
            n++;
        end
        n_checks++;
        if (n != 32) begin
            n_errors++;
            $display("FAIL reset_sweep_len got %0d exp 32", n);
        end
        n_checks++;
        if (busy_count !== '0) begin
            n_errors++;
            $display("FAIL reset_after_busy_count got %0d exp 0", busy_count);
        end
        for (int k = 0; k < NUM_RD; k++) expect_rd(k, '0, 1'b0);
        sb_drain("reset_after_read");
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    task automatic test_bypass();
        idle();
        write_enable = 1'b1;
        w_addr       = 5'd5;
        w_data       = 32'hDEAD_BEEF;
        set_rd(1, 5'd5);
        rd_addr[0 +: ADDR_W] = 5'd5;
        expect_rd(1, 32'hDEAD_BEEF, 1'b0);
        expect_rd(0, '0, 1'b0);
        sb_drain("bypass_same_cycle");
        step();
        mdl[5] = 32'hDEAD_BEEF;
        idle();
        set_rd(1, 5'd5);
        set_rd(2, 5'd0);
        expect_rd(1, 32'hDEAD_BEEF, 1'b0);
        expect_rd(2, '0, 1'b0);
        sb_drain("bypass_stored");
    endtask

    task automatic test_alloc();
        idle();
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
        step();
        idle();
        set_rd(0, 5'd7);
        expect_rd(0, '0, 1'b1);
        sb_drain("alloc_pending");
        n_checks++;
        if (busy_count !== 6'd1) begin
            n_errors++;
            $display("FAIL alloc_busy_count got %0d exp 1", busy_count);
        end
        write_enable = 1'b1;
        w_addr       = 5'd7;
        w_data       = 32'h12;
        expect_rd(0, 32'h12, 1'b0);
        sb_drain("alloc_writeback_same_cycle");
        step();
        mdl[7] = 32'h12;
        n_checks++;
        if (busy_count !== 6'd0) begin
            n_errors++;
            $display("FAIL alloc_wb_busy_count got %0d exp 0", busy_count);
        end
        idle();
        set_rd(0, 5'd7);
        expect_rd(0, 32'h12, 1'b0);
        sb_drain("alloc_after_wb");
    endtask

    task automatic test_alloc_write_same();
        idle();
        alloc_en     = 1'b1;
        alloc_addr   = 5'd9;
        write_enable = 1'b1;
        w_addr       = 5'd9;
        w_data       = 32'h55;
        set_rd(2, 5'd9);
        expect_rd(2, 32'h55, 1'b0);
        sb_drain("aw_same_cycle");
        step();
        mdl[9] = 32'h55;
        idle();
        set_rd(2, 5'd9);
        expect_rd(2, 32'h55, 1'b1);
        sb_drain("aw_after");
        n_checks++;
        if (busy_count !== 6'd1) begin
            n_errors++;
            $display("FAIL aw_busy_count got %0d exp 1", busy_count);
        end
        // Re-alloc of a pending register while writing it back: flag stays set.
        idle();
        alloc_en     = 1'b1;
        alloc_addr   = 5'd9;
        write_enable = 1'b1;
        w_addr       = 5'd9;
        w_data       = 32'h66;
        set_rd(0, 5'd9);
        expect_rd(0, 32'h66, 1'b1);
        sb_drain("realloc_wb_same_cycle");
        step();
        mdl[9] = 32'h66;
        // Re-alloc of pending r9 and write of non-pending r5: count unchanged.
        idle();
        alloc_en     = 1'b1;
        alloc_addr   = 5'd9;
        write_enable = 1'b1;
        w_addr       = 5'd5;
        w_data       = 32'h5A5A_5A5A;
        step();
        mdl[5] = 32'h5A5A_5A5A;
        n_checks++;
        if (busy_count !== 6'd1) begin
            n_errors++;
            $display("FAIL realloc_busy_count got %0d exp 1", busy_count);
        end
        idle();
        set_rd(0, 5'd9);
        set_rd(1, 5'd5);
        expect_rd(0, 32'h66, 1'b1);
        expect_rd(1, 32'h5A5A_5A5A, 1'b0);
        sb_drain("realloc_read");
    endtask

    task automatic test_r0();
        idle();
        write_enable = 1'b1;
        w_addr       = 5'd0;
        w_data       = 32'hFFFF_FFFF;
        alloc_en     = 1'b1;
        alloc_addr   = 5'd0;
        set_rd(0, 5'd0);
        expect_rd(0, '0, 1'b0);
        sb_drain("r0_same_cycle");
        step();
        n_checks++;
        if (busy_count !== 6'd1) begin
            n_errors++;
            $display("FAIL r0_busy_count got %0d exp 1", busy_count);
        end
        idle();
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        expect_rd(0, '0, 1'b0);
        expect_rd(1, '0, 1'b0);
        sb_drain("r0_after");
    endtask

    task automatic test_clear_full();
        int n;
        idle();
        write_enable = 1'b1;
        w_addr       = 5'd3;
        w_data       = 32'h10;
        alloc_en     = 1'b1;
        alloc_addr   = 5'd3;
        step();
        n_checks++;
        if (busy_count !== 6'd2) begin
            n_errors++;
            $display("FAIL clr_pre_busy_count got %0d exp 2", busy_count);
        end
        idle();
        set_rd(0, 5'd3);
        expect_rd(0, 32'h10, 1'b1);
        sb_drain("clr_pre_read");
        // Clear wins over a same-cycle write and alloc.
        idle();
        clear_req    = 1'b1;
        write_enable = 1'b1;
        w_addr       = 5'd4;
        w_data       = 32'hAA;
        alloc_en     = 1'b1;
        alloc_addr   = 5'd4;
        step();
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_enter_ready got %b exp 0", ready);
        end
        n_checks++;
        if (busy_count !== 6'd0) begin
            n_errors++;
            $display("FAIL clr_enter_busy_count got %0d exp 0", busy_count);
        end
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            idle();
            if (n == 10) begin
                clear_req    = 1'b1;
                write_enable = 1'b1;
                w_addr       = 5'd6;
                w_data       = 32'h77;
                alloc_en     = 1'b1;
                alloc_addr   = 5'd6;
            end
            if (n == 5) begin
                set_rd(0, 5'd3);
                set_rd(1, 5'd5);
                expect_rd(0, '0, 1'b0);
                expect_rd(1, '0, 1'b0);
                sb_drain("clr_sweep_read");
            end
            step();
            n++;
        end
        n_checks++;
        if (n != 32) begin
            n_errors++;
            $display("FAIL clr_sweep_len got %0d exp 32", n);
        end
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        set_rd(2, 5'd6);
        expect_rd(0, '0, 1'b0);
        expect_rd(1, '0, 1'b0);
        expect_rd(2, '0, 1'b0);
        sb_drain("clr_after_read");
        n_checks++;
        if (busy_count !== 6'd0) begin
            n_errors++;
            $display("FAIL clr_after_busy_count got %0d exp 0", busy_count);
        end
    endtask

    task automatic test_clear_reset();
        int n;
        idle();
        write_enable = 1'b1;
        w_addr       = 5'd3;
        w_data       = 32'h10;
        alloc_en     = 1'b1;
        alloc_addr   = 5'd3;
        step();
        idle();
        clear_req = 1'b1;
        step();
        idle();
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || busy_count !== 6'd0) begin
            n_errors++;
            $display("FAIL crst_state got ready=%b count=%0d exp ready=0 count=0",
                     ready, busy_count);
        end
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 32) begin
            n_errors++;
            $display("FAIL crst_sweep_len got %0d exp 32", n);
        end
        n_checks++;
        if (busy_count !== 6'd0) begin
            n_errors++;
            $display("FAIL crst_busy_count got %0d exp 0", busy_count);
        end
        set_rd(2, 5'd3);
        expect_rd(2, '0, 1'b0);
        sb_drain("crst_read_r3");
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] v;
        logic [ADDR_W-1:0] a;
        for (int i = 1; i < DEPTH; i++) begin
            idle();
            v            = $urandom;
            write_enable = 1'b1;
            w_addr       = ADDR_W'(i);
            w_data       = v;
            set_rd(0, ADDR_W'(i));
            set_rd(2, ADDR_W'(i - 1));
            expect_rd(0, v, 1'b0);
            expect_rd(2, mdl[i-1], 1'b0);
            sb_drain("b2b_write");
            step();
            mdl[i] = v;
        end
        for (int i = 1; i < DEPTH; i += NUM_RD) begin
            idle();
            for (int k = 0; k < NUM_RD; k++) begin
                a = (i + k < DEPTH) ? ADDR_W'(i + k) : '0;
                set_rd(k, a);
                expect_rd(k, mdl[a], 1'b0);
            end
            sb_drain("b2b_read");
            step();
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_bypass();
        test_alloc();
        test_alloc_write_same();
        test_r0();
        test_clear_full();
        test_clear_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
